// File: rtl/s_reg_mct_sequencer.sv
// Memory-cycle-time sequencer: twelve-pulse timepulse counter, S-register strobes,
// counter/instruction address arbitration with a starvation guard, and a sticky parity alarm.
module s_reg_mct_sequencer #(
    parameter int NTP     = 12,
    parameter int MAXCTR  = 3,
    parameter bit PAR_CHK = 1'b1
) (
    input  logic        CLOCK,
    input  logic        rst,
    input  logic        STEP,
    input  logic        CTRREQ,
    input  logic [11:0] CTRADR,
    input  logic [11:0] INSTADR,
    input  logic        PARGOOD,
    input  logic        PALCLR,
    output logic [3:0]  TPNUM,
    output logic        CSG,
    output logic        WSG_,
    output logic        TPARG_,
    output logic [11:0] SADR,
    output logic        RPTSEL,
    output logic        CTRACK,
    output logic        MCTEND,
    output logic        PALARM
);

    localparam logic [3:0] LASTTP  = 4'(NTP);
    localparam logic [3:0] CLEARTP = 4'(NTP - 1);
    localparam logic [3:0] PARTP   = 4'd7;
    localparam logic [1:0] MAXRUN  = 2'(MAXCTR);

    logic [1:0] run;
    logic       atLast;
    logic       atClear;
    logic       atParity;
    logic       ctrGrant;
    logic       parFail;

    // Every strobe is qualified by STEP so a stalled sequencer emits nothing.
    always_comb begin
        atLast   = STEP && (TPNUM == LASTTP);
        atClear  = STEP && (TPNUM == CLEARTP);
        atParity = STEP && (TPNUM == PARTP);
        ctrGrant = CTRREQ && (run < MAXRUN);
        parFail  = PAR_CHK && atParity && !PARGOOD;
    end

    assign CSG    = atClear;
    assign WSG_   = !atLast;
    assign MCTEND = atLast;
    assign TPARG_ = !atParity;
    assign CTRACK = atLast && ctrGrant;

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            TPNUM <= 4'd1;
        end else if (STEP) begin
            TPNUM <= (TPNUM == LASTTP) ? 4'd1 : TPNUM + 4'd1;
        end
    end

    // The address for the next MCT is chosen on the last timepulse; run counts
    // consecutive counter MCTs so an instruction MCT is forced once it hits MAXCTR.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            SADR   <= 12'd0;
            RPTSEL <= 1'b0;
            run    <= 2'd0;
        end else if (atLast) begin
            if (ctrGrant) begin
                SADR   <= CTRADR;
                RPTSEL <= 1'b1;
                run    <= run + 2'd1;
            end else begin
                SADR   <= INSTADR;
                RPTSEL <= 1'b0;
                run    <= 2'd0;
            end
        end
    end

    // A parity failure outranks a simultaneous clear request.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            PALARM <= 1'b0;
        end else if (parFail) begin
            PALARM <= 1'b1;
        end else if (PALCLR) begin
            PALARM <= 1'b0;
        end
    end

endmodule
